// File: rtl/execute_pkg.sv
// Shared types for the RV64 execute stage: decoded instruction, execute result,
// forwarding entry, ALU/M-extension op ordering and divider op descriptor.
package execute_pkg;

  typedef logic [63:0] word_t;
  typedef logic        u1;

  localparam int DIV_ITERS_DEFAULT = 64;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_LUI, OP_AUIPC, OP_MUL,
    OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW, OP_MULW,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW,
    OP_LOAD, OP_STORE, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU
  } alu_op_e;

  typedef struct packed {
    logic sgn;
    logic word;
    logic rem;
  } div_op_t;

  typedef struct packed {
    alu_op_e alu_op;
    u1       regwrite;
    u1       rtype;
  } ctl_t;

  typedef struct packed {
    word_t       pc;
    logic [31:0] raw_instr;
    ctl_t        ctl;
    u1           valid;
    word_t       rd1;
    word_t       rd2;
    word_t       imm;
    logic [4:0]  dst;
  } decode_data_t;

  typedef struct packed {
    word_t       pc;
    logic [31:0] raw_instr;
    ctl_t        ctl;
    u1           valid;
    word_t       result;
    word_t       rd2;
    logic [4:0]  dst;
  } excute_data_t;

  typedef struct packed {
    logic [4:0] dst;
    word_t      data;
    u1          ismem;
  } forward_t;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  function automatic word_t sext32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_div_op(alu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic div_op_t div_op_of(alu_op_e op);
    div_op_t d;
    d.sgn  = op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
    d.word = op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    d.rem  = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    return d;
  endfunction

endpackage

// File: rtl/execute_divider.sv
// Iterative restoring radix-2 divider on operand magnitudes, one quotient bit
// per cycle, with sign fix-up and divide-by-zero handling on the way out.
module execute_divider
  import execute_pkg::*;
#(
  parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  word_t   a,
  input  word_t   b,
  input  div_op_t op,
  input  logic    abort,
  output logic    busy,
  output logic    done,
  output word_t   quotient,
  output word_t   remainder
);

  localparam logic [6:0] ITERS = 7'(DIV_ITERS);

  typedef enum logic {D_IDLE, D_RUN} dstate_e;

  dstate_e    state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  word_t      dvd_q, dvd_d;
  word_t      rem_q, rem_d;
  word_t      dvs_q, dvs_d;
  word_t      x_q, x_d;
  logic       dz_q, dz_d;
  logic       qneg_q, qneg_d;
  logic       rneg_q, rneg_d;
  logic       word_q, word_d;

  word_t       a_ext, b_ext;
  logic        a_neg, b_neg;
  logic [64:0] shifted;
  logic        fits;
  word_t       q_raw, r_raw;
  logic        unused_rem;

  assign unused_rem = op.rem;

  assign a_ext = op.word ? (op.sgn ? sext32(a[31:0]) : {32'd0, a[31:0]}) : a;
  assign b_ext = op.word ? (op.sgn ? sext32(b[31:0]) : {32'd0, b[31:0]}) : b;
  assign a_neg = op.sgn & a_ext[63];
  assign b_neg = op.sgn & b_ext[63];

  // Partial remainder stays below the divisor, so the shifted value needs 65 bits.
  assign shifted = {rem_q, dvd_q[63]};
  assign fits    = shifted >= {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    x_d     = x_q;
    dz_d    = dz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    word_d  = word_q;
    case (state_q)
      D_IDLE: begin
        if (start && !abort) begin
          state_d = D_RUN;
          cnt_d   = ITERS;
          dvd_d   = a_neg ? -a_ext : a_ext;
          dvs_d   = b_neg ? -b_ext : b_ext;
          rem_d   = '0;
          x_d     = a_ext;
          dz_d    = (b_ext == '0);
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          word_d  = op.word;
        end
      end
      D_RUN: begin
        if (abort || cnt_q == 7'd0) begin
          state_d = D_IDLE;
        end else begin
          cnt_d = cnt_q - 7'd1;
          if (fits) begin
            rem_d = shifted[63:0] - dvs_q;
            dvd_d = {dvd_q[62:0], 1'b1};
          end else begin
            rem_d = shifted[63:0];
            dvd_d = {dvd_q[62:0], 1'b0};
          end
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= D_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      x_q     <= '0;
      dz_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      word_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      x_q     <= x_d;
      dz_q    <= dz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      word_q  <= word_d;
    end
  end

  assign busy = (state_q == D_RUN);
  assign done = (state_q == D_RUN) && (cnt_q == 7'd0);

  // MIN / -1 falls out naturally: |MIN| / 1 with no negation yields MIN.
  assign q_raw = dz_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
  assign r_raw = dz_q ? x_q : (rneg_q ? -rem_q : rem_q);

  assign quotient  = word_q ? sext32(q_raw[31:0]) : q_raw;
  assign remainder = word_q ? sext32(r_raw[31:0]) : r_raw;

endmodule

// File: rtl/execute.sv
// Execute stage: inline ALU, address/branch resolution, divide sequencing
// wrapper around the iterative divider, output register and forward entry.
//
// state  | meaning
// S_IDLE | no divide in flight; a valid div op starts the divider
// S_BUSY | divider iterating; front-end stalled
// S_DONE | result latched; released to dataE once memory is not stalled
module execute
  import execute_pkg::*;
#(
  parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  decode_data_t dataD,
  input  logic         stall_m,
  input  logic         flush,
  output excute_data_t dataE,
  output logic         stall_e,
  output forward_t     forward_e,
  output logic         redirect,
  output word_t        redirect_pc
);

  alu_op_e      op;
  logic         is_div, div_valid, is_load, is_branch, is_jump, taken;
  word_t        opa, opb, addr, pc4, result;
  logic [5:0]   sh;
  logic [4:0]   shw;
  logic [31:0]  sllw, srlw, sraw, mulw;

  div_state_e   state_q, state_d;
  word_t        div_res_q, div_res_d;
  excute_data_t dataE_q, dataE_d;
  logic         div_start, div_done, unused_div_busy;
  word_t        div_quot, div_rem;
  div_op_t      dop;

  assign op        = dataD.ctl.alu_op;
  assign is_div    = is_div_op(op);
  assign div_valid = dataD.valid & is_div;
  assign dop       = div_op_of(op);
  assign is_load   = (op == OP_LOAD);
  assign is_branch = op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  assign is_jump   = op inside {OP_JAL, OP_JALR};

  assign opa  = (op inside {OP_AUIPC, OP_JAL, OP_JALR}) ? dataD.pc : dataD.rd1;
  assign opb  = dataD.ctl.rtype ? dataD.rd2 : dataD.imm;
  assign addr = dataD.rd1 + dataD.imm;
  assign pc4  = dataD.pc + 64'd4;
  assign sh   = opb[5:0];
  assign shw  = opb[4:0];
  assign sllw = opa[31:0] << shw;
  assign srlw = opa[31:0] >> shw;
  assign sraw = $signed(opa[31:0]) >>> shw;
  assign mulw = opa[31:0] * opb[31:0];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = opa + opb;
      OP_SUB:   result = opa - opb;
      OP_AND:   result = opa & opb;
      OP_OR:    result = opa | opb;
      OP_XOR:   result = opa ^ opb;
      OP_SLL:   result = opa << sh;
      OP_SRL:   result = opa >> sh;
      OP_SRA:   result = word_t'($signed(opa) >>> sh);
      OP_SLT:   result = {63'd0, $signed(opa) < $signed(opb)};
      OP_SLTU:  result = {63'd0, opa < opb};
      OP_LUI:   result = dataD.imm;
      OP_AUIPC: result = opa + dataD.imm;
      OP_MUL:   result = opa * opb;
      OP_ADDW:  result = sext32(opa[31:0] + opb[31:0]);
      OP_SUBW:  result = sext32(opa[31:0] - opb[31:0]);
      OP_SLLW:  result = sext32(sllw);
      OP_SRLW:  result = sext32(srlw);
      OP_SRAW:  result = sext32(sraw);
      OP_MULW:  result = sext32(mulw);
      OP_LOAD, OP_STORE: result = addr;
      OP_JAL, OP_JALR:   result = pc4;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU,
      OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW: result = div_res_q;
      default:  result = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = dataD.rd1 == dataD.rd2;
      OP_BNE:  taken = dataD.rd1 != dataD.rd2;
      OP_BLT:  taken = $signed(dataD.rd1) <  $signed(dataD.rd2);
      OP_BGE:  taken = $signed(dataD.rd1) >= $signed(dataD.rd2);
      OP_BLTU: taken = dataD.rd1 <  dataD.rd2;
      OP_BGEU: taken = dataD.rd1 >= dataD.rd2;
      default: taken = 1'b0;
    endcase
  end

  assign stall_e     = stall_m | (div_valid & (state_q != S_DONE));
  assign redirect    = dataD.valid & ~stall_e & (is_jump | (is_branch & taken));
  assign redirect_pc = (op == OP_JALR) ? (addr & ~64'd1) : (dataD.pc + dataD.imm);

  execute_divider #(.DIV_ITERS(DIV_ITERS)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .a         (dataD.rd1),
    .b         (dataD.rd2),
    .op        (dop),
    .abort     (flush),
    .busy      (unused_div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    div_res_d = div_res_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_valid && !flush) begin
          div_start = 1'b1;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (div_done) begin
          div_res_d = dop.rem ? div_rem : div_quot;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || !stall_m) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // stall_m freezes dataE even when flush is asserted; flush only drops valid.
  always_comb begin
    dataE_d = dataE_q;
    if (!stall_m) begin
      if (flush || stall_e) begin
        dataE_d.valid = 1'b0;
      end else begin
        dataE_d.pc        = dataD.pc;
        dataE_d.raw_instr = dataD.raw_instr;
        dataE_d.ctl       = dataD.ctl;
        dataE_d.valid     = dataD.valid;
        dataE_d.result    = result;
        dataE_d.rd2       = dataD.rd2;
        dataE_d.dst       = dataD.dst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_res_q <= '0;
      dataE_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_res_q <= div_res_d;
      dataE_q   <= dataE_d;
    end
  end

  assign dataE = dataE_q;

  always_comb begin
    forward_e.dst   = (dataD.ctl.regwrite & dataD.valid) ? dataD.dst : 5'd0;
    forward_e.data  = result;
    forward_e.ismem = is_load;
    if (div_valid && state_q != S_DONE) begin
      forward_e.dst   = dataD.dst;
      forward_e.ismem = 1'b1;
    end
  end

endmodule
